// File: rtl/dram_nbank_mem.sv
// Banked word memory: NBANKS interleaved ports share one array (bank b, address a -> a*NBANKS+b),
// with byte-enabled writes, a fixed-latency read pipeline and optional periodic busy injection.
module dram_nbank_mem #(
    parameter int NBANKS      = 2,
    parameter int WIDTH       = 64,
    parameter int AWIDTH      = 14,
    parameter int RD_LATENCY  = 2,
    parameter int BUSY_PERIOD = 0
) (
    input  logic                        CLK,
    input  logic                        RESET_N,
    input  logic [NBANKS-1:0]           En,
    input  logic [NBANKS-1:0]           Wr,
    input  logic [NBANKS*AWIDTH-1:0]    Addr,
    input  logic [NBANKS*WIDTH/8-1:0]   ByteEn,
    input  logic [NBANKS*WIDTH-1:0]     WrData,
    output logic [NBANKS*WIDTH-1:0]     Data,
    output logic [NBANKS-1:0]           Busy
);

    localparam int NB    = WIDTH / 8;
    localparam int IW    = AWIDTH + $clog2(NBANKS);
    localparam int DEPTH = NBANKS << AWIDTH;

    logic [WIDTH-1:0]        r_mem [DEPTH];
    logic [IW-1:0]           w_idx [NBANKS];
    logic [NBANKS-1:0]       w_acc;
    logic [NBANKS-1:0]       w_wr;
    logic [NBANKS-1:0]       w_rd;
    logic [NBANKS*WIDTH-1:0] w_rd_dat;

    logic [NBANKS-1:0]       r_vld [RD_LATENCY];
    logic [NBANKS*WIDTH-1:0] r_dat [RD_LATENCY];
    logic [NBANKS*WIDTH-1:0] r_data;

    // Address interleave, request acceptance and array read-out per bank
    always_comb begin
        w_acc    = En & ~Busy & {NBANKS{RESET_N}};
        w_wr     = w_acc & Wr;
        w_rd     = w_acc & ~Wr;
        w_rd_dat = {(NBANKS*WIDTH){1'b0}};
        for (int b = 0; b < NBANKS; b++) begin
            w_idx[b] = IW'(Addr[b*AWIDTH +: AWIDTH]) * IW'(NBANKS) + IW'(b);
            w_rd_dat[b*WIDTH +: WIDTH] = r_mem[w_idx[b]];
        end
    end

    // Byte-merged writes; the array is deliberately outside the reset domain
    always_ff @(posedge CLK) begin
        for (int b = 0; b < NBANKS; b++) begin
            for (int y = 0; y < NB; y++) begin
                if (w_wr[b] && ByteEn[b*NB + y]) begin
                    r_mem[w_idx[b]][y*8 +: 8] <= WrData[b*WIDTH + y*8 +: 8];
                end
            end
        end
    end

    // Read pipeline: stage 0 captures at acceptance, Data loads RD_LATENCY edges later and holds
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int s = 0; s < RD_LATENCY; s++) begin
                r_vld[s] <= {NBANKS{1'b0}};
                r_dat[s] <= {(NBANKS*WIDTH){1'b0}};
            end
            r_data <= {(NBANKS*WIDTH){1'b0}};
        end else begin
            r_vld[0] <= w_rd;
            r_dat[0] <= w_rd_dat;
            for (int s = 1; s < RD_LATENCY; s++) begin
                r_vld[s] <= r_vld[s-1];
                r_dat[s] <= r_dat[s-1];
            end
            for (int b = 0; b < NBANKS; b++) begin
                if (r_vld[RD_LATENCY-1][b]) begin
                    r_data[b*WIDTH +: WIDTH] <= r_dat[RD_LATENCY-1][b*WIDTH +: WIDTH];
                end
            end
        end
    end

    assign Data = r_data;

    generate
        if (BUSY_PERIOD == 0) begin : g_nobusy
            assign Busy = {NBANKS{1'b0}};
        end else begin : g_busy
            localparam int CW = (BUSY_PERIOD > 1) ? $clog2(BUSY_PERIOD) : 1;
            logic [CW-1:0] r_cnt;

            // Free-running busy slot counter, 0..BUSY_PERIOD-1
            always_ff @(posedge CLK or negedge RESET_N) begin
                if (!RESET_N) begin
                    r_cnt <= {CW{1'b0}};
                end else if (r_cnt == CW'(BUSY_PERIOD - 1)) begin
                    r_cnt <= {CW{1'b0}};
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end

            // Busy decode depends only on the registered counter
            always_comb begin
                Busy = {NBANKS{1'b0}};
                for (int b = 0; b < NBANKS; b++) begin
                    Busy[b] = (r_cnt == CW'(b));
                end
            end
        end
    endgenerate

endmodule
